// File: rtl/alu_seq.sv
// alu_seq: sequencer that accepts one ALU request at a time, drives an
// external clocked ALU, waits ALU_LAT cycles for its result and returns
// the result together with the echoed request tag.
//
// Optional feature: define ALU_SEQ_FLAGS_EN to add the rsp_zero / rsp_neg
// result flags. They are registered alongside rsp_data. Without the macro
// those ports do not exist.
//
// State sequence per request: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// The mandatory IDLE cycle after each response is deliberate: the block
// never overlaps two operations, so the ALU operand registers belong to
// exactly one request from acceptance until the response handshake.

module alu_seq #(
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [1:0]        req_op,
    input  logic [TAG_W-1:0]  req_tag,

    output logic              alu_ena,
    output logic [31:0]       alu_x,
    output logic [31:0]       alu_y,
    output logic [1:0]        alu_op,
    input  logic [31:0]       alu_out,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,

    output logic              busy,
    output logic [15:0]       op_count
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              rsp_zero,
    output logic              rsp_neg
`endif
);

    // Opcode encoding shared with the external ALU.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    // The wait counter is 3 bits wide because ALU_LAT is limited to 1..7.
    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t             state;
    logic [2:0]         wait_cnt;
    logic [TAG_W-1:0]   tag_q;
    logic               capture;

    // The ALU result is sampled on the last WAIT cycle, once the counter
    // has run down to zero; the flag logic below keys off the same event.
    assign capture = (state == WAIT) && (wait_cnt == 3'd0);

    // Main sequencer: state, operand latches, handshakes and the response
    // register. Every output is registered so the ALU and the consumer see
    // glitch-free signals that change only on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            alu_ena   <= 1'b0;
            alu_x     <= 32'd0;
            alu_y     <= 32'd0;
            alu_op    <= OP_ADD;
            tag_q     <= '0;
            wait_cnt  <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_tag   <= '0;
            op_count  <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_x     <= req_a;
                        alu_y     <= req_b;
                        alu_op    <= req_op;
                        tag_q     <= req_tag;
                        alu_ena   <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    alu_ena  <= 1'b0;
                    wait_cnt <= LAT_LOAD;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        rsp_data  <= alu_out;
                        rsp_tag   <= tag_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    alu_ena   <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Result flags are derived straight from alu_out at the capture edge so
    // they always describe the value that lands in rsp_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_zero <= 1'b0;
            rsp_neg  <= 1'b0;
        end else if (capture) begin
            rsp_zero <= (alu_out == 32'd0);
            rsp_neg  <= alu_out[31];
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

    logic [1:0] unused_ops;
    assign unused_ops = OP_SUB ^ OP_AND ^ OP_XOR;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq. Two instances are used: dut_a with
// ALU_LAT=1 for most steps and dut_b with ALU_LAT=3 for the long-latency
// case. Each instance gets a small clocked ALU model whose result appears
// ALU_LAT cycles after the enable cycle.

module tb_alu_seq;

    localparam int TAG_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic             clk;
    logic             rst;
    logic             req_valid_a, req_valid_b;
    logic [31:0]      req_a, req_b;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_ready;

    logic             req_ready_a, alu_ena_a, rsp_valid_a, busy_a;
    logic [31:0]      alu_x_a, alu_y_a, alu_out_a, rsp_data_a;
    logic [1:0]       alu_op_a;
    logic [TAG_W-1:0] rsp_tag_a;
    logic [15:0]      op_count_a;

    logic             req_ready_b, alu_ena_b, rsp_valid_b, busy_b;
    logic [31:0]      alu_x_b, alu_y_b, alu_out_b, rsp_data_b;
    logic [1:0]       alu_op_b;
    logic [TAG_W-1:0] rsp_tag_b;
    logic [15:0]      op_count_b;

`ifdef ALU_SEQ_FLAGS_EN
    logic             rsp_zero_a, rsp_neg_a, rsp_zero_b, rsp_neg_b;
`endif

    int checks = 0;
    int errors = 0;
    int ena_cnt_a = 0;
    int ena_base;
    int j;
    bit seen;

    alu_seq #(.TAG_W(TAG_W), .ALU_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_ena(alu_ena_a), .alu_x(alu_x_a), .alu_y(alu_y_a), .alu_op(alu_op_a),
        .alu_out(alu_out_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_a), .rsp_tag(rsp_tag_a),
        .busy(busy_a), .op_count(op_count_a)
`ifdef ALU_SEQ_FLAGS_EN
        , .rsp_zero(rsp_zero_a), .rsp_neg(rsp_neg_a)
`endif
    );

    alu_seq #(.TAG_W(TAG_W), .ALU_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_ena(alu_ena_b), .alu_x(alu_x_b), .alu_y(alu_y_b), .alu_op(alu_op_b),
        .alu_out(alu_out_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_b), .rsp_tag(rsp_tag_b),
        .busy(busy_b), .op_count(op_count_b)
`ifdef ALU_SEQ_FLAGS_EN
        , .rsp_zero(rsp_zero_b), .rsp_neg(rsp_neg_b)
`endif
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                         input logic [1:0] op);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            default: return x ^ y;
        endcase
    endfunction

    // One-stage ALU model for dut_a (latency 1).
    always @(posedge clk) begin
        if (alu_ena_a) alu_out_a <= alu_f(alu_x_a, alu_y_a, alu_op_a);
    end

    // Three-stage ALU model for dut_b (latency 3).
    logic [31:0] b_s1, b_s2;
    always @(posedge clk) begin
        if (alu_ena_b) b_s1 <= alu_f(alu_x_b, alu_y_b, alu_op_b);
        b_s2      <= b_s1;
        alu_out_b <= b_s2;
    end

    // Counts alu_ena pulses of dut_a.
    always @(posedge clk) begin
        if (alu_ena_a) ena_cnt_a <= ena_cnt_a + 1;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    // Presents a request to the selected instance at a falling edge and
    // returns at the falling edge after the accepting rising edge, with the
    // request inputs scrambled to show they are no longer used.
    task automatic applyStimulus(input bit sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic [TAG_W-1:0] tag);
        req_a   = a;
        req_b   = b;
        req_op  = op;
        req_tag = tag;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_a   = 32'hDEADBEEF;
        req_b   = 32'h12345678;
        req_op  = ~op;
        req_tag = ~tag;
    endtask

    // Waits (bounded) for rsp_valid and checks the number of cycles since
    // the accepting edge.
    task automatic waitResp(input bit sel, input int exp_cycles);
        int n;
        n = 0;
        while (!(sel ? rsp_valid_b : rsp_valid_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(sel ? "latency_b" : "latency_a", 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_a = 32'd0;
        req_b = 32'd0;
        req_op = OP_ADD;
        req_tag = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        checkOutput("rst_req_ready", 32'(req_ready_a), 32'd1);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        checkOutput("rst_alu_ena", 32'(alu_ena_a), 32'd0);
        checkOutput("rst_op_count", 32'(op_count_a), 32'd0);
        checkOutput("rst_alu_x", alu_x_a, 32'd0);
        checkOutput("rst_alu_op", 32'(alu_op_a), 32'd0);
        checkOutput("rst_rsp_tag", 32'(rsp_tag_a), 32'd0);
        checkOutput("rst_rsp_data", rsp_data_a, 32'd0);
        checkOutput("rst_b_req_ready", 32'(req_ready_b), 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("rst_rsp_zero", 32'(rsp_zero_a), 32'd0);
        checkOutput("rst_rsp_neg", 32'(rsp_neg_a), 32'd0);
`endif

        // AND request abandoned by a reset during WAIT.
        applyStimulus(0, 32'hFFFF0000, 32'h0F0F0F0F, OP_AND, 4'd5);
        checkOutput("and_issue_ena", 32'(alu_ena_a), 32'd1);
        @(negedge clk);
        checkOutput("and_in_wait_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_rsp_valid", 32'(rsp_valid_a), 32'd0);
        checkOutput("abort_busy", 32'(busy_a), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready_a), 32'd1);
        checkOutput("abort_alu_x", alu_x_a, 32'd0);
        checkOutput("abort_rsp_data", rsp_data_a, 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid_a) seen = 1'b1;
        end
        checkOutput("abort_no_rsp", 32'(seen), 32'd0);
        checkOutput("abort_op_count", 32'(op_count_a), 32'd0);

        // ADD 5+3, tag 2, latency 1: one enable pulse, response 3 cycles later.
        ena_base = ena_cnt_a;
        applyStimulus(0, 32'h00000005, 32'h00000003, OP_ADD, 4'd2);
        checkOutput("add_alu_ena_c1", 32'(alu_ena_a), 32'd1);
        checkOutput("add_req_ready_c1", 32'(req_ready_a), 32'd0);
        checkOutput("add_busy_c1", 32'(busy_a), 32'd1);
        checkOutput("add_alu_x", alu_x_a, 32'h00000005);
        checkOutput("add_alu_y", alu_y_a, 32'h00000003);
        checkOutput("add_alu_op", 32'(alu_op_a), 32'(OP_ADD));
        @(negedge clk);
        checkOutput("add_alu_ena_c2", 32'(alu_ena_a), 32'd0);
        checkOutput("add_rsp_valid_c2", 32'(rsp_valid_a), 32'd0);
        checkOutput("add_alu_x_hold", alu_x_a, 32'h00000005);
        @(negedge clk);
        checkOutput("add_rsp_valid_c3", 32'(rsp_valid_a), 32'd0);
        @(negedge clk);
        checkOutput("add_rsp_valid_c4", 32'(rsp_valid_a), 32'd1);
        checkOutput("add_rsp_data", rsp_data_a, 32'h00000008);
        checkOutput("add_rsp_tag", 32'(rsp_tag_a), 32'd2);
        @(negedge clk);
        checkOutput("add_rsp_done", 32'(rsp_valid_a), 32'd0);
        checkOutput("add_op_count", 32'(op_count_a), 32'd1);
        checkOutput("add_idle_ready", 32'(req_ready_a), 32'd1);
        checkOutput("add_idle_busy", 32'(busy_a), 32'd0);
        checkOutput("add_ena_pulses", 32'(ena_cnt_a - ena_base), 32'd1);

        // SUB 0-1 wraps to all ones.
        applyStimulus(0, 32'h00000000, 32'h00000001, OP_SUB, 4'd3);
        waitResp(0, 3);
        checkOutput("sub_rsp_data", rsp_data_a, 32'hFFFFFFFF);
        checkOutput("sub_rsp_tag", 32'(rsp_tag_a), 32'd3);
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("sub_rsp_neg", 32'(rsp_neg_a), 32'd1);
        checkOutput("sub_rsp_zero", 32'(rsp_zero_a), 32'd0);
`endif
        @(negedge clk);
        checkOutput("sub_op_count", 32'(op_count_a), 32'd2);

        // XOR to zero with the consumer stalled; a second request is ignored.
        rsp_ready = 1'b0;
        ena_base = ena_cnt_a;
        applyStimulus(0, 32'hA5A5A5A5, 32'hA5A5A5A5, OP_XOR, 4'd7);
        waitResp(0, 3);
        for (int k = 0; k < 10; k++) begin
            req_valid_a = 1'b1;
            req_a = 32'h00000001;
            req_b = 32'h00000001;
            req_op = OP_ADD;
            req_tag = 4'd9;
            @(negedge clk);
            checkOutput("xor_hold_valid", 32'(rsp_valid_a), 32'd1);
            checkOutput("xor_hold_data", rsp_data_a, 32'h00000000);
            checkOutput("xor_hold_tag", 32'(rsp_tag_a), 32'd7);
            checkOutput("xor_hold_ready", 32'(req_ready_a), 32'd0);
        end
`ifdef ALU_SEQ_FLAGS_EN
        checkOutput("xor_rsp_zero", 32'(rsp_zero_a), 32'd1);
        checkOutput("xor_rsp_neg", 32'(rsp_neg_a), 32'd0);
`endif
        req_valid_a = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("xor_released", 32'(rsp_valid_a), 32'd0);
        checkOutput("xor_op_count", 32'(op_count_a), 32'd3);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid_a || busy_a) seen = 1'b1;
        end
        checkOutput("xor_no_queued_req", 32'(seen), 32'd0);
        checkOutput("xor_ena_pulses", 32'(ena_cnt_a - ena_base), 32'd1);

        // op_count wrap: preset to 0xFFFF in IDLE, then one more operation
        // whose add also wraps modulo 2^32.
        force dut_a.op_count = 16'hFFFF;
        @(negedge clk);
        release dut_a.op_count;
        @(negedge clk);
        checkOutput("wrap_preset", 32'(op_count_a), 32'h0000FFFF);
        applyStimulus(0, 32'hFFFFFFFF, 32'h00000002, OP_ADD, 4'd1);
        waitResp(0, 3);
        checkOutput("wrap_add_data", rsp_data_a, 32'h00000001);
        @(negedge clk);
        checkOutput("wrap_op_count", 32'(op_count_a), 32'h00000000);

        // Latency 3 instance: ADD 1+1 answers five cycles after accept.
        applyStimulus(1, 32'h00000001, 32'h00000001, OP_ADD, 4'd3);
        checkOutput("lat3_alu_ena", 32'(alu_ena_b), 32'd1);
        waitResp(1, 5);
        checkOutput("lat3_rsp_data", rsp_data_b, 32'h00000002);
        checkOutput("lat3_rsp_tag", 32'(rsp_tag_b), 32'd3);
        @(negedge clk);
        checkOutput("lat3_op_count", 32'(op_count_b), 32'd1);
        checkOutput("lat3_idle_ready", 32'(req_ready_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
